mac_acc_16: RTL and testbench

//  Sequential multiply-accumulate stage wrapped around the combinational 16x16 array multiplier.

---
 rtl/mac_pkg.sv | 17 +
 rtl/mac_acc_add.sv | 26 ++
 rtl/mac_acc_16.sv | 114 +++++++++++
 tb/tb_mac_acc_16.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// Shared types and widths for the mac_acc_16 multiply-accumulate slice.
// Build option: MAC_SAT_EN selects a saturating accumulator in mac_acc_add.
package mac_pkg;

  localparam int OPW       = 16;
  localparam int PW        = 32;
  localparam int ACC_W_DEF = 40;
  localparam int CNT_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } state_e;

endpackage

// File: rtl/mac_acc_add.sv
// Accumulator adder with carry-out detect.
// Build option: MAC_SAT_EN clamps the sum to all-ones on carry-out instead of wrapping.
module mac_acc_add
  import mac_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic [ACC_W-1:0] acc_i,
  input  logic [PW-1:0]    prod_i,
  output logic [ACC_W-1:0] sum_o,
  output logic             carry_o
);

  logic [ACC_W:0] wideSum;

  assign wideSum = {1'b0, acc_i} + {1'b0, ACC_W'(prod_i)};
  assign carry_o = wideSum[ACC_W];

`ifdef MAC_SAT_EN
  // An all-ones accumulator carries again on any nonzero product, so the clamp holds.
  assign sum_o = carry_o ? {ACC_W{1'b1}} : wideSum[ACC_W-1:0];
`else
  assign sum_o = wideSum[ACC_W-1:0];
`endif

endmodule

// File: rtl/mac_acc_16.sv
// Three-stage multiply-accumulate around an external 16x16 multiplier; returns dot product,
// beat count and sticky overflow per vector. Build option: MAC_SAT_EN (saturating accumulator).
module mac_acc_16
  import mac_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OPW-1:0]   in_a,
  input  logic [OPW-1:0]   in_b,
  input  logic             in_last,
  output logic [OPW-1:0]   mul_a,
  output logic [OPW-1:0]   mul_b,
  input  logic [PW-1:0]    mul_p,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic [CNT_W-1:0] out_cnt,
  output logic             out_ovf
);

  state_e             state_q, state_d;
  logic               s1Valid_q, s1Last_q;
  logic [OPW-1:0]     mulA_q, mulB_q;
  logic               s2Valid_q, s2Last_q;
  logic [PW-1:0]      prod_q;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic [ACC_W-1:0]   sum;
  logic               carry;
  logic               accept;
  logic               handoff;

  assign in_ready  = (state_q == IDLE) || (state_q == ACCUM);
  assign out_valid = (state_q == HOLD);
  assign accept    = in_valid && in_ready;
  assign handoff   = (state_q == HOLD) && out_ready;

  assign mul_a   = mulA_q;
  assign mul_b   = mulB_q;
  assign out_acc = acc_q;
  assign out_cnt = cnt_q;
  assign out_ovf = ovf_q;

  mac_acc_add #(.ACC_W(ACC_W)) u_add (
    .acc_i   (acc_q),
    .prod_i  (prod_q),
    .sum_o   (sum),
    .carry_o (carry)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = in_last ? DRAIN : ACCUM;
      ACCUM:   if (accept && in_last) state_d = DRAIN;
      DRAIN:   if (s2Valid_q && s2Last_q) state_d = HOLD;
      HOLD:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Results are cleared on handoff so the next vector starts from zero; bubbles leave them alone.
  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (handoff) begin
      acc_d = '0;
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (s2Valid_q) begin
      acc_d = sum;
      cnt_d = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
      ovf_d = ovf_q | carry;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      s1Valid_q <= 1'b0;
      s1Last_q  <= 1'b0;
      mulA_q    <= '0;
      mulB_q    <= '0;
      s2Valid_q <= 1'b0;
      s2Last_q  <= 1'b0;
      prod_q    <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      s1Valid_q <= accept;
      s1Last_q  <= accept && in_last;
      if (accept) begin
        mulA_q <= in_a;
        mulB_q <= in_b;
      end
      s2Valid_q <= s1Valid_q;
      s2Last_q  <= s1Valid_q && s1Last_q;
      if (s1Valid_q) prod_q <= mul_p;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

endmodule

// File: tb/tb_mac_acc_16.sv
// Directed bench for mac_acc_16: a default-width instance and a narrow one (ACC_W=32, CNT_W=2).
// Honors MAC_SAT_EN for the expected overflow result.
module tb_mac_acc_16;

  typedef struct packed {
    logic             sel;
    logic [3:0]       n;
    logic [5:0][15:0] a;
    logic [5:0][15:0] b;
    logic [5:0][3:0]  gap;
    logic [7:0]       holdCyc;
    logic [39:0]      expAcc;
    logic [7:0]       expCnt;
    logic             expOvf;
    logic [3:0]       expLat;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sel = 1'b0;
  logic        inValid = 1'b0, inLast = 1'b0, outReady = 1'b0;
  logic [15:0] inA = '0, inB = '0;

  logic        inReady0, outValid0, ovf0;
  logic [15:0] mulA0, mulB0;
  logic [31:0] mulP0;
  logic [39:0] acc0;
  logic [7:0]  cnt0;

  logic        inReady1, outValid1, ovf1;
  logic [15:0] mulA1, mulB1;
  logic [31:0] mulP1;
  logic [31:0] acc1;
  logic [1:0]  cnt1;

  logic        curInReady, curOutValid, curOvf;
  logic [39:0] curAcc;
  logic [7:0]  curCnt;

  int total = 0;
  int bad   = 0;
  vec_t vecs[8];

  always #5 clk = ~clk;

  // Exact-product multiplier model for each instance.
  assign mulP0 = mulA0 * mulB0;
  assign mulP1 = mulA1 * mulB1;

  assign curInReady  = sel ? inReady1 : inReady0;
  assign curOutValid = sel ? outValid1 : outValid0;
  assign curOvf      = sel ? ovf1 : ovf0;
  assign curAcc      = sel ? {8'b0, acc1} : acc0;
  assign curCnt      = sel ? {6'b0, cnt1} : cnt0;

  mac_acc_16 u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(inValid && !sel), .in_ready(inReady0),
    .in_a(inA), .in_b(inB), .in_last(inLast),
    .mul_a(mulA0), .mul_b(mulB0), .mul_p(mulP0),
    .out_valid(outValid0), .out_ready(outReady && !sel),
    .out_acc(acc0), .out_cnt(cnt0), .out_ovf(ovf0)
  );

  mac_acc_16 #(.ACC_W(32), .CNT_W(2)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(inValid && sel), .in_ready(inReady1),
    .in_a(inA), .in_b(inB), .in_last(inLast),
    .mul_a(mulA1), .mul_b(mulB1), .mul_p(mulP1),
    .out_valid(outValid1), .out_ready(outReady && sel),
    .out_acc(acc1), .out_cnt(cnt1), .out_ovf(ovf1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Drives one vector, waits for the result, checks it, optionally stalls, then hands it off.
  task automatic applyStimulus(input vec_t v);
    int  lat;
    logic readyLeak, holdBad, acceptMiss;
    readyLeak  = 1'b0;
    holdBad    = 1'b0;
    acceptMiss = 1'b0;
    sel = v.sel;
    for (int i = 0; i < int'(v.n); i++) begin
      inValid = 1'b0;
      repeat (int'(v.gap[i])) tick();
      inA     = v.a[i];
      inB     = v.b[i];
      inLast  = (i == int'(v.n) - 1);
      inValid = 1'b1;
      if (!curInReady) acceptMiss = 1'b1;
      tick();
      if (v.expLat != 0 && !v.sel) begin
        checkOutput("mulA", {48'b0, mulA0}, {48'b0, v.a[i]});
        checkOutput("mulB", {48'b0, mulB0}, {48'b0, v.b[i]});
      end
    end
    inValid = 1'b0;
    inLast  = 1'b0;
    checkOutput("acceptReady", {63'b0, acceptMiss}, 64'd0);
    lat = 1;
    while (!curOutValid && lat < 30) begin
      if (curInReady) readyLeak = 1'b1;
      tick();
      lat++;
    end
    checkOutput("outValid", {63'b0, curOutValid}, 64'd1);
    if (v.expLat != 0) checkOutput("latency", 64'(lat), {60'b0, v.expLat});
    checkOutput("outAcc", {24'b0, curAcc}, {24'b0, v.expAcc});
    checkOutput("outCnt", {56'b0, curCnt}, {56'b0, v.expCnt});
    checkOutput("outOvf", {63'b0, curOvf}, {63'b0, v.expOvf});
    for (int h = 0; h < int'(v.holdCyc); h++) begin
      tick();
      if (curAcc !== v.expAcc || !curOutValid || curInReady) holdBad = 1'b1;
    end
    if (v.holdCyc != 0) checkOutput("holdStable", {63'b0, holdBad}, 64'd0);
    checkOutput("inReadyLow", {63'b0, readyLeak || curInReady}, 64'd0);
    outReady = 1'b1;
    tick();
    outReady = 1'b0;
    checkOutput("idleReady", {63'b0, curInReady}, 64'd1);
    checkOutput("idleValid", {63'b0, curOutValid}, 64'd0);
    checkOutput("clearedAcc", {24'b0, curAcc}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t v;
    for (int k = 0; k < 8; k++) vecs[k] = '0;
    // single beat with latency and operand-register check
    vecs[0].n = 1; vecs[0].a[0] = 3; vecs[0].b[0] = 5;
    vecs[0].expAcc = 15; vecs[0].expCnt = 1; vecs[0].expLat = 3;
    // back-to-back 1..4 squared
    vecs[1].n = 4;
    for (int k = 0; k < 4; k++) begin vecs[1].a[k] = 16'(k + 1); vecs[1].b[k] = 16'(k + 1); end
    vecs[1].expAcc = 30; vecs[1].expCnt = 4;
    // same vector with two bubbles and a 5-cycle consumer stall
    vecs[2] = vecs[1];
    vecs[2].gap[1] = 1; vecs[2].gap[3] = 1; vecs[2].holdCyc = 5;
    // 32-bit accumulator overflow
    vecs[3].sel = 1'b1; vecs[3].n = 2;
    vecs[3].a[0] = 16'hFFFF; vecs[3].b[0] = 16'hFFFF;
    vecs[3].a[1] = 16'hFFFF; vecs[3].b[1] = 16'hFFFF;
`ifdef MAC_SAT_EN
    vecs[3].expAcc = 40'h00FFFFFFFF;
`else
    vecs[3].expAcc = 40'h00FFFC0002;
`endif
    vecs[3].expCnt = 2; vecs[3].expOvf = 1'b1;
    // same pair fits in 40 bits
    vecs[4] = vecs[3];
    vecs[4].sel = 1'b0; vecs[4].expAcc = 40'h01FFFC0002; vecs[4].expOvf = 1'b0;
    // 2-bit counter saturates on 5 beats
    vecs[5].sel = 1'b1; vecs[5].n = 5;
    for (int k = 0; k < 5; k++) begin vecs[5].a[k] = 1; vecs[5].b[k] = 1; end
    vecs[5].expAcc = 5; vecs[5].expCnt = 3;
    vecs[6] = vecs[5];
    vecs[6].sel = 1'b0; vecs[6].expCnt = 5;
    // overflow flag must not leak into the next vector
    vecs[7].sel = 1'b1; vecs[7].n = 1; vecs[7].expCnt = 1;

    #12;
    checkOutput("rstReady0", {63'b0, inReady0}, 64'd1);
    checkOutput("rstValid0", {63'b0, outValid0}, 64'd0);
    checkOutput("rstAcc0", {24'b0, acc0}, 64'd0);
    checkOutput("rstMulA0", {48'b0, mulA0}, 64'd0);
    checkOutput("rstReady1", {63'b0, inReady1}, 64'd1);
    #10 rst_n = 1'b1;
    tick();

    for (int k = 0; k < 8; k++) begin
      $display("[TB] vector %0d", k);
      applyStimulus(vecs[k]);
    end

    // async reset while draining a vector
    $display("[TB] reset during drain");
    sel = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      inA = 16'(k); inB = 16'(k); inLast = (k == 3); inValid = 1'b1;
      tick();
    end
    inValid = 1'b0; inLast = 1'b0;
    checkOutput("drainReady", {63'b0, inReady0}, 64'd0);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("asyncReady", {63'b0, inReady0}, 64'd1);
    checkOutput("asyncValid", {63'b0, outValid0}, 64'd0);
    checkOutput("asyncAcc", {24'b0, acc0}, 64'd0);
    checkOutput("asyncCnt", {56'b0, cnt0}, 64'd0);
    checkOutput("asyncMulA", {48'b0, mulA0}, 64'd0);
    #2 rst_n = 1'b1;
    repeat (4) tick();
    checkOutput("postRstValid", {63'b0, outValid0}, 64'd0);
    checkOutput("postRstAcc", {24'b0, acc0}, 64'd0);
    checkOutput("postRstReady", {63'b0, inReady0}, 64'd1);
    v = '0;
    v.n = 1; v.a[0] = 2; v.b[0] = 7; v.expAcc = 14; v.expCnt = 1;
    applyStimulus(v);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
